// File: rtl/ones_comp_checksum_accum.sv
// -----------------------------------------------------------------------------
// ones_comp_checksum_accum
//
// Streaming one's-complement accumulator. It sums a packet of WIDTH-bit words
// with end-around carry, one word per clock, and reports the sum and its
// complement as an Internet-style checksum.
//
// Parameters
//   WIDTH    data word / accumulator width in bits (>= 2)
//   COUNT_W  width of the accepted-word counter
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset (aborts any packet)
//   start         in   begin a new packet (sampled in IDLE only)
//   in_valid      in   input word valid
//   in_ready      out  accumulator can accept a word (ACCUM state)
//   in_data       in   input word
//   in_last       in   final word of packet (only meaningful on accept)
//   out_valid     out  result available (DONE state)
//   out_ready     in   consumer accepts result
//   sum_out       out  one's-complement sum of the packet
//   checksum_out  out  ~sum_out
//   word_count    out  words accepted in current/last packet (saturating)
//   busy          out  high in ACCUM or DONE
//   chk_ok        out  only with OCSUM_VERIFY_EN: out_valid & (sum == all-ones)
//
// Build option
//   OCSUM_VERIFY_EN  when defined, adds the chk_ok port. A packet that carries
//                    its own checksum sums to all-ones and verifies good.
// -----------------------------------------------------------------------------
module ones_comp_checksum_accum #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum_out,
    output logic [WIDTH-1:0]   checksum_out,
    output logic [COUNT_W-1:0] word_count,
    output logic               busy
`ifdef OCSUM_VERIFY_EN
    ,
    output logic               chk_ok
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    // One's-complement add with end-around carry. The carry fold cannot
    // itself carry out: if the first add overflowed, its low part is at most
    // 2^WIDTH-2, so adding the carry back stays in range.
    function automatic logic [WIDTH-1:0] oc_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
    endfunction

    state_t               state_r;
    logic [WIDTH-1:0]     acc_r;
    logic [COUNT_W-1:0]   word_count_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;

    logic                 accept_s;
    logic [WIDTH-1:0]     acc_next_s;
    logic [COUNT_W-1:0]   count_next_s;

    // Handshake decode and next accumulator / saturating counter values.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        acc_next_s   = oc_add(acc_r, in_data);
        count_next_s = (word_count_r == CNT_MAX) ? word_count_r
                                                 : (word_count_r + CNT_ONE);
    end

    // Packet FSM with registered handshake/status outputs kept in step with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            acc_r        <= {WIDTH{1'b0}};
            word_count_r <= {COUNT_W{1'b0}};
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_ACCUM;
                        acc_r        <= {WIDTH{1'b0}};
                        word_count_r <= {COUNT_W{1'b0}};
                        in_ready_r   <= 1'b1;
                        busy_r       <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r        <= acc_next_s;
                        word_count_r <= count_next_s;
                        if (in_last) begin
                            state_r     <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here, even in the
                    // release cycle; it must be reasserted once back in IDLE.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef OCSUM_VERIFY_EN
    logic chk_ok_r;

    // Verify flag: set on entry to DONE when the final sum is all-ones,
    // cleared when the result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_ok_r <= 1'b0;
        end else if ((state_r == ST_ACCUM) && accept_s && in_last) begin
            chk_ok_r <= (acc_next_s == ALL_ONES);
        end else if ((state_r == ST_DONE) && out_ready) begin
            chk_ok_r <= 1'b0;
        end else begin
            chk_ok_r <= chk_ok_r;
        end
    end

    assign chk_ok = chk_ok_r;
`endif

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign busy         = busy_r;
    assign word_count   = word_count_r;
    assign sum_out      = acc_r;
    assign checksum_out = acc_r ^ ALL_ONES;

endmodule

// File: tb/tb_ones_comp_checksum_accum.sv
// -----------------------------------------------------------------------------
// Testbench for ones_comp_checksum_accum. Two instances share one stimulus:
// dut_a uses the default COUNT_W=8, dut_b uses COUNT_W=2 so that counter
// saturation is exercised on short packets. Expected sums come from folding
// the plain integer total of the packet down to 16 bits.
// -----------------------------------------------------------------------------
module tb_ones_comp_checksum_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [15:0] sum_a, csum_a;
    logic [7:0]  cnt_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [15:0] sum_b, csum_b;
    logic [1:0]  cnt_b;
`ifdef OCSUM_VERIFY_EN
    logic        chk_ok_a, chk_ok_b;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] pkt[$];

    ones_comp_checksum_accum #(.WIDTH(16), .COUNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .sum_out(sum_a),
        .checksum_out(csum_a), .word_count(cnt_a), .busy(busy_a)
`ifdef OCSUM_VERIFY_EN
        , .chk_ok(chk_ok_a)
`endif
    );

    ones_comp_checksum_accum #(.WIDTH(16), .COUNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .sum_out(sum_b),
        .checksum_out(csum_b), .word_count(cnt_b), .busy(busy_b)
`ifdef OCSUM_VERIFY_EN
        , .chk_ok(chk_ok_b)
`endif
    );

    initial clk = 1'b0;
    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference one's-complement sum: add everything as integers, then fold carries.
    function automatic logic [15:0] ref_sum();
        logic [63:0] t;
        t = 64'd0;
        foreach (pkt[i]) t = t + {48'd0, pkt[i]};
        while ((t >> 16) != 64'd0) t = (t & 64'h0000_0000_0000_FFFF) + (t >> 16);
        return t[15:0];
    endfunction

    function automatic logic [31:0] sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    // Check the idle-state handshake outputs of both instances.
    task automatic check_idle(input string tag);
        check({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_rdy_a"}, {31'd0, in_ready_a}, 32'd0);
        check({tag, "_ov_a"}, {31'd0, out_valid_a}, 32'd0);
        check({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
    endtask

    // Stream pkt through both DUTs, optionally with input gaps and result backpressure.
    task automatic run_packet(input string tag, input int gap_pct, input bit bp);
        logic [15:0] exp_sum;
        int n;
        n = pkt.size();
        exp_sum = ref_sum();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_accum_busy"}, {31'd0, busy_a}, 32'd1);
        check({tag, "_accum_rdy"}, {31'd0, in_ready_a}, 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                step();
                check({tag, "_gap_ov"}, {31'd0, out_valid_a}, 32'd0);
            end
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == n - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_ov_a"}, {31'd0, out_valid_a}, 32'd1);
        check({tag, "_rdy_done"}, {31'd0, in_ready_a}, 32'd0);
        check({tag, "_sum_a"}, {16'd0, sum_a}, {16'd0, exp_sum});
        check({tag, "_csum_a"}, {16'd0, csum_a}, {16'd0, ~exp_sum});
        check({tag, "_cnt_a"}, {24'd0, cnt_a}, sat(n, 255));
        check({tag, "_sum_b"}, {16'd0, sum_b}, {16'd0, exp_sum});
        check({tag, "_cnt_b"}, {30'd0, cnt_b}, sat(n, 3));
`ifdef OCSUM_VERIFY_EN
        check({tag, "_chk_ok"}, {31'd0, chk_ok_a}, {31'd0, exp_sum == 16'hFFFF});
`endif
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                start    = (k == 2);
                in_valid = 1'b1;
                in_data  = 16'($urandom);
                in_last  = 1'b1;
                step();
                check({tag, "_bp_ov"}, {31'd0, out_valid_a}, 32'd1);
                check({tag, "_bp_rdy"}, {31'd0, in_ready_a}, 32'd0);
                check({tag, "_bp_sum"}, {16'd0, sum_a}, {16'd0, exp_sum});
                check({tag, "_bp_cnt"}, {24'd0, cnt_a}, sat(n, 255));
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        out_ready = 1'b1;
        start     = bp;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check_idle({tag, "_rel"});
        check({tag, "_rel_sum"}, {16'd0, sum_a}, {16'd0, exp_sum});
`ifdef OCSUM_VERIFY_EN
        check({tag, "_rel_chk"}, {31'd0, chk_ok_a}, 32'd0);
`endif
        step();
        check({tag, "_stay_idle"}, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #3;
        check_idle("reset");
        check("reset_sum", {16'd0, sum_a}, 32'd0);
        check("reset_csum", {16'd0, csum_a}, 32'h0000_FFFF);
        check("reset_cnt", {24'd0, cnt_a}, 32'd0);
`ifdef OCSUM_VERIFY_EN
        check("reset_chk", {31'd0, chk_ok_a}, 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Words presented in IDLE without start are ignored.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_idle("idle_ignore");
        check("idle_ignore_sum", {16'd0, sum_a}, 32'd0);

        // RFC example.
        pkt = '{16'h0001, 16'hF203, 16'hF4F5, 16'hF6F7};
        run_packet("rfc", 0, 1'b0);
        check("rfc_const", {16'd0, sum_a}, 32'h0000_DDF2);
        check("rfc_const_csum", {16'd0, csum_a}, 32'h0000_220D);

        // End-around carry, and negative zero kept as all-ones.
        pkt = '{16'hFFFF, 16'h0001};
        run_packet("carry", 0, 1'b0);
        check("carry_const", {16'd0, sum_a}, 32'h0000_0001);
        pkt = '{16'h0001, 16'hFFFE};
        run_packet("negzero", 0, 1'b0);
        check("negzero_const", {16'd0, sum_a}, 32'h0000_FFFF);

        // Backpressure with an ignored start pulse.
        pkt = '{16'hABCD, 16'h8000, 16'h8001};
        run_packet("bp", 0, 1'b1);

        // Single-word packet and saturation of the 2-bit counter.
        pkt = '{16'h7777};
        run_packet("single", 0, 1'b0);
        pkt = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        run_packet("sat6", 30, 1'b0);
        check("sat6_const", {16'd0, sum_b}, 32'h0000_0006);
        check("sat6_cnt_b", {30'd0, cnt_b}, 32'd3);

        // Verify path: packet that includes its own checksum, then a corrupted one.
        pkt = '{16'h0001, 16'hF203, 16'hF4F5, 16'hF6F7, 16'h220D};
        run_packet("verify_good", 20, 1'b0);
        pkt = '{16'h0002, 16'hF203, 16'hF4F5, 16'hF6F7, 16'h220D};
        run_packet("verify_bad", 0, 1'b0);

        // Long packet saturating the 8-bit counter.
        pkt.delete();
        for (int i = 0; i < 260; i++) pkt.push_back(16'($urandom));
        run_packet("long", 5, 1'b0);

        // Randomised packets with gaps, occasional backpressure and extreme words.
        for (int p = 0; p < 20; p++) begin
            pkt.delete();
            for (int i = 0; i < int'($urandom_range(8, 1)); i++) begin
                case ($urandom_range(3))
                    0:       pkt.push_back(16'hFFFF);
                    1:       pkt.push_back(16'h0000);
                    default: pkt.push_back(16'($urandom));
                endcase
            end
            run_packet("rand", 25, 1'($urandom_range(1)));
        end

        // Reset during ACCUM aborts the packet immediately.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            in_data  = 16'h1111;
            in_last  = 1'b0;
            step();
        end
        check("gap_cnt", {24'd0, cnt_a}, 32'd2);
        check("gap_sum", {16'd0, sum_a}, 32'h0000_2222);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_sum", {16'd0, sum_a}, 32'd0);
        check("midrst_cnt", {24'd0, cnt_a}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_idle("post_rst");

        // Normal operation resumes after the abort.
        pkt = '{16'h4321, 16'hC000, 16'h5000};
        run_packet("after_rst", 10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
